// File: rtl/pipelined_kogge_stone_adder_pkg.sv
// rtl/pipelined_kogge_stone_adder_pkg.sv - shared types and helpers for the pipelined Kogge-Stone adder
// Purpose: ceiling-log2 helper, stage-index constants and the per-stage flag bundle
// that travels alongside the P/G vectors through every pipeline register.
package pipelined_kogge_stone_adder_pkg;

  // Index of the operand-capture stage; prefix level k lives in stage k.
  localparam int STAGE_INPUT = 0;
  localparam int FIRST_PREFIX_STAGE = 1;

  // Flags carried with each stage. cin is kept because sum bit 0 needs it
  // directly; the MSBs are kept so overflow can be formed at the end.
  typedef struct packed {
    logic valid;
    logic cin;
    logic a_msb;
    logic b_msb;
  } stage_flags_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipelined_kogge_stone_adder_ks_prefix_level.sv
// rtl/pipelined_kogge_stone_adder_ks_prefix_level.sv - one combinational Kogge-Stone prefix level
// Purpose: combines each bit's (P,G) with the pair SPAN bits below it.
// Ports: p, g        - propagate/generate vectors entering the level
//        p_next, g_next - vectors leaving the level
// Bits below SPAN have no partner and pass through unchanged, which is what
// makes non-power-of-2 widths work without special casing.
module ks_prefix_level #(
  parameter int PRECISION = 16,
  parameter int SPAN = 1
) (
  input  logic [PRECISION-1:0] p,
  input  logic [PRECISION-1:0] g,
  output logic [PRECISION-1:0] p_next,
  output logic [PRECISION-1:0] g_next
);

  always_comb begin
    p_next = p;
    g_next = g;
    for (int i = SPAN; i < PRECISION; i++) begin
      g_next[i] = g[i] | (p[i] & g[i-SPAN]);
      p_next[i] = p[i] & p[i-SPAN];
    end
  end

endmodule

// File: rtl/pipelined_kogge_stone_adder.sv
// rtl/pipelined_kogge_stone_adder.sv - fully pipelined Kogge-Stone adder/subtractor with valid/ready
// Purpose: A + B' + cin with one register per prefix level, one op per cycle.
// Ports: clk_i/rst_ni            - clock, synchronous active-low reset
//        in_valid_i/in_ready_o   - input handshake; operand_a_i, operand_b_i, carry_i, sub_i
//        out_valid_o/out_ready_i - output handshake; result_o, carry_o, overflow_o
module pipelined_kogge_stone_adder
  import pipelined_kogge_stone_adder_pkg::*;
#(
  parameter int PRECISION = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PRECISION-1:0] operand_a_i,
  input  logic [PRECISION-1:0] operand_b_i,
  input  logic                 carry_i,
  input  logic                 sub_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PRECISION-1:0] result_o,
  output logic                 carry_o,
  output logic                 overflow_o
);

  localparam int NUM_STEPS = clog2(PRECISION);

  // p/g are the running group vectors; p_bit keeps the per-bit propagate,
  // which the final sum needs after p has been folded into group terms.
  typedef struct packed {
    logic [PRECISION-1:0] p;
    logic [PRECISION-1:0] g;
    logic [PRECISION-1:0] p_bit;
    stage_flags_t         flags;
  } stage_t;

  stage_t               stage_q [NUM_STEPS+1];
  stage_t               input_stage;
  logic [PRECISION-1:0] level_p [NUM_STEPS];
  logic [PRECISION-1:0] level_g [NUM_STEPS];
  logic                 en;
  logic [PRECISION-1:0] carries;

  // The whole pipeline stalls together when the output is held.
  assign en         = !stage_q[NUM_STEPS].flags.valid | out_ready_i;
  assign in_ready_o = en;

  always_comb begin
    logic [PRECISION-1:0] b_eff;
    logic [PRECISION-1:0] p_vec;
    logic [PRECISION-1:0] g_vec;
    logic                 cin;
    b_eff    = sub_i ? ~operand_b_i : operand_b_i;
    cin      = sub_i | carry_i;
    p_vec    = operand_a_i ^ b_eff;
    g_vec    = operand_a_i & b_eff;
    // Fold carry-in into bit 0 so the prefix tree needs no extra input.
    g_vec[0] = g_vec[0] | (p_vec[0] & cin);
    input_stage.p           = p_vec;
    input_stage.g           = g_vec;
    input_stage.p_bit       = p_vec;
    input_stage.flags.valid = in_valid_i;
    input_stage.flags.cin   = cin;
    input_stage.flags.a_msb = operand_a_i[PRECISION-1];
    input_stage.flags.b_msb = b_eff[PRECISION-1];
  end

  for (genvar k = 0; k < NUM_STEPS; k++) begin : g_level
    ks_prefix_level #(
      .PRECISION(PRECISION),
      .SPAN     (1 << k)
    ) u_level (
      .p      (stage_q[k].p),
      .g      (stage_q[k].g),
      .p_next (level_p[k]),
      .g_next (level_g[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k <= NUM_STEPS; k++) stage_q[k] <= '0;
    end else if (en) begin
      stage_q[STAGE_INPUT] <= input_stage;
      for (int k = FIRST_PREFIX_STAGE; k <= NUM_STEPS; k++) begin
        stage_q[k].p     <= level_p[k-1];
        stage_q[k].g     <= level_g[k-1];
        stage_q[k].p_bit <= stage_q[k-1].p_bit;
        stage_q[k].flags <= stage_q[k-1].flags;
      end
    end
  end

  // After the last level g[i] is the carry out of bits i..0 including cin.
  assign carries     = {stage_q[NUM_STEPS].g[PRECISION-2:0], stage_q[NUM_STEPS].flags.cin};
  assign result_o    = stage_q[NUM_STEPS].p_bit ^ carries;
  assign carry_o     = stage_q[NUM_STEPS].g[PRECISION-1];
  assign out_valid_o = stage_q[NUM_STEPS].flags.valid;
  assign overflow_o  = (stage_q[NUM_STEPS].flags.a_msb == stage_q[NUM_STEPS].flags.b_msb) &
                       (result_o[PRECISION-1] != stage_q[NUM_STEPS].flags.a_msb);

endmodule

// File: tb/tb_pipelined_kogge_stone_adder.sv
// tb/tb_pipelined_kogge_stone_adder.sv - self-checking bench for the pipelined Kogge-Stone adder
module tb_pipelined_kogge_stone_adder;

  typedef struct {
    logic [65:0] e;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cin, sub;
  logic [63:0] a_in, b_in;
  logic        rdy [4];
  logic        ov  [4];
  logic        co  [4];
  logic        of  [4];
  logic [63:0] res [4];
  logic [15:0] r16;
  logic [7:0]  r8;
  logic [12:0] r13;
  logic [63:0] r64;
  int          W [4] = '{16, 8, 13, 64};
  exp_t        q [4][$];
  logic [65:0] last_obs [4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          lat_on = 1'b1;

  always #5 clk = ~clk;

  pipelined_kogge_stone_adder #(.PRECISION(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .operand_a_i(a_in[15:0]), .operand_b_i(b_in[15:0]), .carry_i(cin), .sub_i(sub),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .result_o(r16), .carry_o(co[0]), .overflow_o(of[0]));
  pipelined_kogge_stone_adder #(.PRECISION(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .operand_a_i(a_in[7:0]), .operand_b_i(b_in[7:0]), .carry_i(cin), .sub_i(sub),
    .out_valid_o(ov[1]), .out_ready_i(1'b1), .result_o(r8), .carry_o(co[1]), .overflow_o(of[1]));
  pipelined_kogge_stone_adder #(.PRECISION(13)) u_dut13 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
    .operand_a_i(a_in[12:0]), .operand_b_i(b_in[12:0]), .carry_i(cin), .sub_i(sub),
    .out_valid_o(ov[2]), .out_ready_i(1'b1), .result_o(r13), .carry_o(co[2]), .overflow_o(of[2]));
  pipelined_kogge_stone_adder #(.PRECISION(64)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[3]),
    .operand_a_i(a_in), .operand_b_i(b_in), .carry_i(cin), .sub_i(sub),
    .out_valid_o(ov[3]), .out_ready_i(1'b1), .result_o(r64), .carry_o(co[3]), .overflow_o(of[3]));

  assign res[0] = {48'd0, r16};
  assign res[1] = {56'd0, r8};
  assign res[2] = {51'd0, r13};
  assign res[3] = r64;

  // Reference: plain w-bit arithmetic on A + B' + cin.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input logic s);
    logic [63:0] mask, am, bm, r;
    logic [64:0] sum;
    logic        cy, ovf;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (s ? ~b : b) & mask;
    sum  = {1'b0, am} + {1'b0, bm} + {64'd0, (s | c)};
    r    = sum[63:0] & mask;
    cy   = sum[w];
    ovf  = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
    return {ovf, cy, r};
  endfunction

  function automatic int latency_of(input int w);
    int lv;
    lv = 0;
    while ((1 << lv) < w) lv++;
    return lv + 1;
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [65:0] obs;
    logic        ordy;
    @(negedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        ordy = (i == 0) ? out_ready : 1'b1;
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            check($sformatf("spurious_out_w%0d", W[i]), {65'd0, ov[i]}, 66'd0);
          end else begin
            obs = {of[i], co[i], res[i]};
            check($sformatf("result_w%0d", W[i]), obs, q[i][0].e);
            if (ordy) begin
              if (lat_on) check($sformatf("latency_w%0d", W[i]), 66'(cyc - q[i][0].acc), 66'(latency_of(W[i])));
              last_obs[i] = obs;
              void'(q[i].pop_front());
            end
          end
        end
        if (in_valid && rdy[i]) q[i].push_back('{model(W[i], a_in, b_in, cin, sub), cyc});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_left", 66'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 66'd0);
  endtask

  task automatic op(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
    a_in = a; b_in = b; cin = c; sub = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic randomize_inputs();
    a_in = {$urandom, $urandom};
    b_in = {$urandom, $urandom};
    cin  = 1'($urandom_range(0, 1));
    sub  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("reset_valid", {65'd0, ov[0]}, 66'd0);
    check("reset_outputs", {of[0], co[0], res[0]}, 66'd0);
    check("reset_ready", {65'd0, rdy[0]}, 66'd1);

    op(64'hFFFF, 64'h0001, 1'b0, 1'b0);
    check("ffff_plus_1", last_obs[0], {1'b0, 1'b1, 64'h0000});
    op(64'h7FFF, 64'h0001, 1'b0, 1'b0);
    check("7fff_plus_1", last_obs[0], {1'b1, 1'b0, 64'h8000});
    op(64'h1234, 64'h0000, 1'b1, 1'b0);
    check("carry_in", last_obs[0], {1'b0, 1'b0, 64'h1235});
    op(64'h0000, 64'h0001, 1'b1, 1'b1);
    check("0_minus_1", last_obs[0], {1'b0, 1'b0, 64'hFFFF});
    op(64'h8000, 64'h0001, 1'b1, 1'b1);
    check("8000_minus_1", last_obs[0], {1'b1, 1'b1, 64'h7FFF});

    for (int n = 0; n < 100; n++) begin
      randomize_inputs();
      in_valid = 1'b1;
      check("stream_ready", {65'd0, rdy[0]}, 66'd1);
      step();
    end
    in_valid = 1'b0;
    drain();

    lat_on = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && rdy[0]; n++) begin
      randomize_inputs();
      step();
    end
    check("stall_filled", {65'd0, rdy[0]}, 66'd0);
    for (int n = 0; n < 7; n++) begin
      randomize_inputs();
      step();
      check("stall_ready", {65'd0, rdy[0]}, 66'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    drain();
    lat_on = 1'b1;

    in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset_valid", {65'd0, ov[0]}, 66'd0);
    check("midreset_outputs", {of[0], co[0], res[0]}, 66'd0);
    check("midreset_outputs_w64", {of[3], co[3], res[3]}, 66'd0);
    check("midreset_ready", {65'd0, rdy[0]}, 66'd1);
    for (int n = 0; n < 12; n++) step();

    lat_on = 1'b0;
    for (int n = 0; n < 150; n++) begin
      randomize_inputs();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
